// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame source and receiver:
// the receiver state encoding, default frame format and frame length.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_STOP_BITS  = 2;
  localparam int unsigned DEF_PARITY_ODD = 0;

  // Start bit + data + parity + stop bits.
  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input int unsigned stop_bits);
    return 1 + data_bits + 1 + stop_bits;
  endfunction

endpackage

// File: rtl/serial_frame_stats.sv
// Bring-up statistics for the frame receiver: a wrapping good-frame counter
// and an error-frame counter that saturates at all-ones.
module serial_frame_stats
  import serial_frame_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_mem,
  input  logic             done,
  input  logic             parity_err,
  input  logic             frame_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  always_ff @(posedge clk or negedge rst_mem) begin
    if (!rst_mem) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else if (done) begin
      if (!parity_err && !frame_err) begin
        good_cnt <= good_cnt + 1'b1;
      end else if (err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// One-bit-per-clock serial frame receiver: start, LSB-first data, parity,
// stop bits. Emits each byte with a one-cycle valid strobe and error flags.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS  = DEF_STOP_BITS,
  parameter int unsigned PARITY_ODD = DEF_PARITY_ODD,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_mem,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned IDX_W = $clog2(frame_len(DATA_BITS, STOP_BITS));
  localparam logic        ODD   = (PARITY_ODD != 0);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     idx;
  logic                 acc;
  logic                 par_q;
  logic                 frm_q;

  logic last_stop;
  logic frm_final;

  // The final stop bit is folded in combinationally so the stats counters
  // update on the same edge as the registered outputs.
  assign last_stop = (state == STOP) && (idx == IDX_W'(STOP_BITS - 1));
  assign frm_final = frm_q | ~rx_in;

  always_ff @(posedge clk or negedge rst_mem) begin
    if (!rst_mem) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      acc        <= 1'b0;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_in) begin
            state <= DATA;
            idx   <= '0;
            acc   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          shreg <= {rx_in, shreg[DATA_BITS-1:1]};
          acc   <= acc ^ rx_in;
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            state <= PARITY;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        PARITY: begin
          par_q <= acc ^ rx_in ^ ODD;
          frm_q <= 1'b0;
          idx   <= '0;
          state <= STOP;
        end
        STOP: begin
          if (!rx_in) begin
            frm_q <= 1'b1;
          end
          if (last_stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            data_out   <= shreg;
            parity_err <= par_q;
            frame_err  <= frm_final;
            data_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  serial_frame_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst_mem   (rst_mem),
    .done      (last_stop),
    .parity_err(par_q),
    .frame_err (frm_final),
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: the driver queues the expected byte,
// flags, counters and strobe cycle per frame; a monitor pops on data_valid.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst_mem;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] good_cnt;
  logic [7:0] err_cnt;

  serial_frame_rx #(
    .DATA_BITS (8),
    .STOP_BITS (2),
    .PARITY_ODD(0),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst_mem   (rst_mem),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic [7:0] g;
    logic [7:0] e;
  } exp_t;

  exp_t        q[$];
  int unsigned qc[$];
  logic [7:0]  mg;
  logic [7:0]  me;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  exp_t        mx;
  int unsigned mc;
  always @(negedge clk) begin
    if (rst_mem === 1'b1 && data_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        mx = q.pop_front();
        mc = qc.pop_front();
        check("frame", {data_out, parity_err, frame_err, good_cnt, err_cnt}, mx);
        check("valid_cycle", cyc, mc);
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic [1:0] stops);
    exp_t x;
    @(negedge clk);
    check("busy_idle", busy, 0);
    x.d  = d;
    x.pe = pflip;
    x.fe = ~&stops;
    if (!x.pe && !x.fe) mg = mg + 8'd1;
    else if (me != 8'hFF) me = me + 8'd1;
    x.g = mg;
    x.e = me;
    q.push_back(x);
    qc.push_back(cyc + 12);
    rx_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_data", busy, 1);
      rx_in = d[i];
    end
    @(negedge clk);
    check("busy_par", busy, 1);
    rx_in = (^d) ^ pflip;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("busy_stop", busy, 1);
      rx_in = stops[i];
    end
  endtask

  task automatic idle(input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (chk) check("busy_line_idle", busy, 0);
      rx_in = 1'b1;
    end
  endtask

  task automatic do_reset();
    check("queue_before_reset", q.size(), 0);
    @(negedge clk);
    rst_mem = 1'b0;
    rx_in   = 1'b1;
    #1;
    check("reset_out", {data_out, data_valid, parity_err, frame_err, busy, good_cnt, err_cnt}, 0);
    @(negedge clk);
    rst_mem = 1'b1;
    mg = 8'd0;
    me = 8'd0;
    q.delete();
    qc.delete();
  endtask

  logic [7:0] partial;

  initial begin
    rst_mem = 1'b0;
    rx_in   = 1'b1;
    mg      = 8'd0;
    me      = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {data_out, data_valid, parity_err, frame_err, busy, good_cnt, err_cnt}, 0);
    rst_mem = 1'b1;
    idle(1, 1'b1);

    // Five-frame memory stream, back to back.
    send_frame(8'hAA, 1'b0, 2'b11);
    send_frame(8'h09, 1'b0, 2'b11);
    send_frame(8'hA6, 1'b0, 2'b11);
    send_frame(8'hBB, 1'b0, 2'b11);
    send_frame(8'h09, 1'b0, 2'b11);

    // Parity error, then stop-bit error followed immediately by a clean frame.
    send_frame(8'h09, 1'b1, 2'b11);
    send_frame(8'hAA, 1'b0, 2'b01);
    send_frame(8'h55, 1'b0, 2'b11);

    idle(100, 1'b1);

    // Reset asserted where data bit 5 would be driven.
    partial = 8'hBB;
    @(negedge clk);
    rx_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_in = partial[i];
    end
    do_reset();
    idle(5, 1'b1);
    send_frame(8'hBB, 1'b0, 2'b11);
    idle(3, 1'b0);

    do_reset();
    for (int i = 0; i < 256; i++) send_frame(8'(i * 7 + 3), 1'b0, 2'b11);
    for (int i = 0; i < 300; i++) send_frame(8'(i), 1'b1, 2'b11);
    idle(3, 1'b0);
    check("good_wrap", good_cnt, 8'h00);
    check("err_sat", err_cnt, 8'hFF);
    check("pending_frames", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
